// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM bus arbiter: channel state encodings,
// SRAM region constants, grant encodings and the address decoder.
package sram_arb_pkg;

  // Per-channel sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // addr[31:22] values that select each SRAM chip
  localparam logic [9:0] REGION_BASE = 10'h200;
  localparam logic [9:0] REGION_EXT  = 10'h201;

  // Which requester owns the channel's current transaction
  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  typedef enum logic [1:0] {
    TGT_BASE = 2'd0,
    TGT_EXT  = 2'd1,
    TGT_ERR  = 2'd2
  } target_t;

  // Map the region field of a byte address to its destination
  function automatic target_t decode_target(input logic [9:0] region);
    target_t tgt;
    if (region == REGION_BASE) begin
      tgt = TGT_BASE;
    end else if (region == REGION_EXT) begin
      tgt = TGT_EXT;
    end else begin
      tgt = TGT_ERR;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_channel.sv
// One SRAM channel: grant selection between IF and MEM, IDLE/ACCESS/DONE
// sequencer, pin registers and tri-state data bus control.
// Optional macro ARB_FAIRNESS_EN adds an IF starvation counter that forces
// an IF win after STARVE_LIMIT consecutive contended losses.
module sram_channel
  import sram_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_sel,
  input  logic [19:0] if_word,
  input  logic        mem_sel,
  input  logic        mem_we,
  input  logic [19:0] mem_word,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic        if_ack,
  output logic        mem_ack,
  output logic [31:0] rdata,
  inout  wire  [31:0] ram_data,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  localparam int unsigned CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

  // Configurations outside the supported range show up as this named
  // block in the elaborated hierarchy.
  if (ACCESS_CYCLES < 2 || STARVE_LIMIT < 1) begin : g_illegal_config
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          gnt;
  logic          we_q;
  logic [19:0]   addr_q;
  logic [3:0]    be_n_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic          start;
  logic          grant;
  logic          if_priority;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  // Count consecutive contended IF losses; any IF grant clears the count
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      if (grant == GNT_IF) begin
        starve_cnt <= '0;
      end else if (if_sel && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign if_priority = (starve_cnt == STARVE_MAX);
`else
  assign if_priority = 1'b0;
`endif

  // Grant selection: MEM wins contention unless IF has starved
  always_comb begin
    start = if_sel | mem_sel;
    grant = GNT_IF;
    if (mem_sel && !(if_sel && if_priority)) begin
      grant = GNT_MEM;
    end
  end

  // Sequencer and pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gnt     <= GNT_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_n_q  <= '1;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACCESS;
            cnt   <= '0;
            gnt   <= grant;
            if (grant == GNT_MEM) begin
              addr_q  <= mem_word;
              be_n_q  <= ~mem_be;
              wdata_q <= mem_wdata;
              we_q    <= mem_we;
            end else begin
              addr_q  <= if_word;
              be_n_q  <= '0;
              we_q    <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == LAST_CNT) begin
            state <= ST_DONE;
            if (!we_q) begin
              rdata_q <= ram_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pin controls derive from the registered state; counter 0 of a write is setup
  always_comb begin
    ram_addr = addr_q;
    ram_ce_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    ram_be_n = '1;
    if (state == ST_ACCESS) begin
      ram_ce_n = 1'b0;
      ram_be_n = be_n_q;
      ram_oe_n = we_q;
      ram_we_n = !(we_q && cnt != '0);
    end
  end

  assign ram_data = (state == ST_ACCESS && we_q) ? wdata_q : 'z;

  assign if_ack  = (state == ST_DONE) && (gnt == GNT_IF);
  assign mem_ack = (state == ST_DONE) && (gnt == GNT_MEM);
  assign rdata   = rdata_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// SRAM bus arbiter top: decodes IF/MEM addresses to BaseRAM, ExtRAM or the
// error path, runs one sram_channel per chip and merges acks and read data.
// Optional macro ARB_FAIRNESS_EN enables IF starvation protection per channel.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n
);

  target_t     if_tgt;
  target_t     mem_tgt;
  logic        base_if_sel;
  logic        base_mem_sel;
  logic        ext_if_sel;
  logic        ext_mem_sel;
  logic        base_if_ack;
  logic        base_mem_ack;
  logic        ext_if_ack;
  logic        ext_mem_ack;
  logic [31:0] base_rdata;
  logic [31:0] ext_rdata;
  logic        if_err_q;
  logic        mem_err_q;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr[1:0], mem_addr[1:0]};

  // Route each request to the channel its address selects
  always_comb begin
    if_tgt       = decode_target(if_addr[31:22]);
    mem_tgt      = decode_target(mem_addr[31:22]);
    base_if_sel  = if_req  && (if_tgt  == TGT_BASE);
    ext_if_sel   = if_req  && (if_tgt  == TGT_EXT);
    base_mem_sel = mem_req && (mem_tgt == TGT_BASE);
    ext_mem_sel  = mem_req && (mem_tgt == TGT_EXT);
  end

  // Out-of-range requests ack one cycle later; the self-clear blocks a second pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      if_err_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      if_err_q  <= if_req  && (if_tgt  == TGT_ERR) && !if_err_q;
      mem_err_q <= mem_req && (mem_tgt == TGT_ERR) && !mem_err_q;
    end
  end

  sram_channel #(
    .ACCESS_CYCLES(ACCESS_CYCLES),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_base (
    .clk      (clk),
    .rst      (rst),
    .if_sel   (base_if_sel),
    .if_word  (if_addr[21:2]),
    .mem_sel  (base_mem_sel),
    .mem_we   (mem_we),
    .mem_word (mem_addr[21:2]),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .if_ack   (base_if_ack),
    .mem_ack  (base_mem_ack),
    .rdata    (base_rdata),
    .ram_data (base_ram_data),
    .ram_addr (base_ram_addr),
    .ram_be_n (base_ram_be_n),
    .ram_ce_n (base_ram_ce_n),
    .ram_oe_n (base_ram_oe_n),
    .ram_we_n (base_ram_we_n)
  );

  sram_channel #(
    .ACCESS_CYCLES(ACCESS_CYCLES),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_ext (
    .clk      (clk),
    .rst      (rst),
    .if_sel   (ext_if_sel),
    .if_word  (if_addr[21:2]),
    .mem_sel  (ext_mem_sel),
    .mem_we   (mem_we),
    .mem_word (mem_addr[21:2]),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .if_ack   (ext_if_ack),
    .mem_ack  (ext_mem_ack),
    .rdata    (ext_rdata),
    .ram_data (ext_ram_data),
    .ram_addr (ext_ram_addr),
    .ram_be_n (ext_ram_be_n),
    .ram_ce_n (ext_ram_ce_n),
    .ram_oe_n (ext_ram_oe_n),
    .ram_we_n (ext_ram_we_n)
  );

  // Merge per-channel completions; read data is zero outside an ack
  always_comb begin
    if_ack   = base_if_ack | ext_if_ack | if_err_q;
    if_err   = if_err_q;
    mem_ack  = base_mem_ack | ext_mem_ack | mem_err_q;
    mem_err  = mem_err_q;
    if_rdata = '0;
    if (base_if_ack) begin
      if_rdata = base_rdata;
    end else if (ext_if_ack) begin
      if_rdata = ext_rdata;
    end
    mem_rdata = '0;
    if (base_mem_ack) begin
      mem_rdata = base_rdata;
    end else if (ext_mem_ack) begin
      mem_rdata = ext_rdata;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed scoreboard bench for sram_bus_arbiter with behavioural SRAM models.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  wire  [31:0] base_ram_data;
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  wire  [31:0] ext_ram_data;
  logic [19:0] ext_ram_addr;
  logic [3:0]  ext_ram_be_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

  always #10 clk = ~clk;

  sram_bus_arbiter #(.ACCESS_CYCLES(2), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
  );

  // SRAM models: 64 words each, preload port, byte-masked writes on we_n low
  logic [31:0] base_mem [0:63];
  logic [31:0] ext_mem  [0:63];
  logic        pre_en = 1'b0;
  logic        pre_ext = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[5:0]] : 'z;
  assign ext_ram_data  = (!ext_ram_ce_n  && !ext_ram_oe_n)  ? ext_mem[ext_ram_addr[5:0]]   : 'z;

  always @(posedge clk) begin
    if (pre_en && !pre_ext) base_mem[pre_addr] <= pre_data;
    else if (!base_ram_ce_n && !base_ram_we_n)
      for (int b = 0; b < 4; b++)
        if (!base_ram_be_n[b]) base_mem[base_ram_addr[5:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
  end

  always @(posedge clk) begin
    if (pre_en && pre_ext) ext_mem[pre_addr] <= pre_data;
    else if (!ext_ram_ce_n && !ext_ram_we_n)
      for (int b = 0; b < 4; b++)
        if (!ext_ram_be_n[b]) ext_mem[ext_ram_addr[5:0]][8*b +: 8] <= ext_ram_data[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
    int          ack_cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int base_ce_lo, base_oe_lo, ext_ce_lo, ext_we_lo, ext_we_at;
  logic [19:0] base_addr_seen;
  logic [3:0]  ext_be_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    base_ce_lo = 0; base_oe_lo = 0; ext_ce_lo = 0; ext_we_lo = 0; ext_we_at = 0;
    base_addr_seen = '1; ext_be_seen = '0;
  endtask

  task automatic preload(input logic ext, input logic [5:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_ext = ext; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Called at a negedge: monitor pins, compare acks against the scoreboard
  task automatic sample();
    logic ie, me;
    exp_t e;
    if (!base_ram_ce_n) begin base_ce_lo++; base_addr_seen = base_ram_addr; end
    if (!base_ram_oe_n) base_oe_lo++;
    if (!ext_ram_ce_n) begin ext_ce_lo++; ext_be_seen = ext_ram_be_n; end
    if (!ext_ram_we_n) begin ext_we_lo++; ext_we_at = ext_ce_lo; end
    ie = (if_q.size() > 0) && (if_q[0].ack_cyc == cyc);
    me = (mem_q.size() > 0) && (mem_q[0].ack_cyc == cyc);
    check("if_ack", 32'(if_ack), 32'(ie));
    check("if_err", 32'(if_err), 32'(ie && if_q[0].err));
    check("mem_ack", 32'(mem_ack), 32'(me));
    check("mem_err", 32'(mem_err), 32'(me && mem_q[0].err));
    if (if_ack && if_q.size() > 0) begin
      e = if_q.pop_front();
      if (e.chk_rdata) check("if_rdata", if_rdata, e.rdata);
      if (if_q.size() == 0) if_req = 1'b0;
    end
    if (mem_ack && mem_q.size() > 0) begin
      e = mem_q.pop_front();
      if (e.chk_rdata) check("mem_rdata", mem_rdata, e.rdata);
      if (mem_q.size() == 0) begin mem_req = 1'b0; mem_we = 1'b0; end
    end
  endtask

  task automatic issue_if(input logic [31:0] a, input logic [31:0] d, input logic err, input int lat);
    if_addr = a; if_req = 1'b1;
    if_q.push_back('{rdata: d, err: err, chk_rdata: 1'b1, ack_cyc: cyc + lat});
  endtask

  task automatic issue_mem(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] d, input logic err, input int lat);
    mem_addr = a; mem_we = we; mem_wdata = wd; mem_be = be; mem_req = 1'b1;
    mem_q.push_back('{rdata: d, err: err, chk_rdata: !we, ack_cyc: cyc + lat});
  endtask

  task automatic step(input int budget);
    int n = 0;
    while ((if_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
      @(negedge clk); sample(); n++;
    end
    check("step_timeout_pending", 32'(if_q.size() + mem_q.size()), 32'd0);
    if_q.delete(); mem_q.delete();
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    repeat (2) begin @(negedge clk); sample(); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_if_ack", 32'(if_ack), 0);
    check("rst_mem_ack", 32'(mem_ack), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_base_ctl", {28'b0, base_ram_be_n}, 32'hF);
    check("rst_base_n", {29'b0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n}, 32'h7);
    check("rst_ext_ctl", {28'b0, ext_ram_be_n}, 32'hF);
    check("rst_ext_n", {29'b0, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h7);
    rst = 1'b0;
    preload(1'b0, 6'd1, 32'h3C01_1234);
    preload(1'b0, 6'd0, 32'hCAFE_F00D);
    preload(1'b1, 6'd4, 32'h1234_0000);
    preload(1'b1, 6'd0, 32'h0BAD_C0DE);
    preload(1'b1, 6'd8, 32'h55AA_55AA);

    // 1: IF read from BaseRAM word 1
    clear_mon();
    issue_if(32'h8000_0004, 32'h3C01_1234, 1'b0, 3);
    step(20);
    check("t1_base_addr", {12'b0, base_addr_seen}, 32'h1);
    check("t1_oe_low_cycles", 32'(base_oe_lo), 2);
    check("t1_ce_low_cycles", 32'(base_ce_lo), 2);

    // 2: MEM byte-masked write to ExtRAM, then read back
    clear_mon();
    issue_mem(1'b1, 32'h8040_0010, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 3);
    step(20);
    check("t2_be_n", {28'b0, ext_be_seen}, 32'hC);
    check("t2_we_low_cycles", 32'(ext_we_lo), 1);
    check("t2_we_low_at_access", 32'(ext_we_at), 2);
    issue_mem(1'b0, 32'h8040_0010, 32'h0, 4'hF, 32'h1234_BEEF, 1'b0, 3);
    step(20);

    // 3: IF and MEM contend for BaseRAM, MEM first
    issue_mem(1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 3);
    issue_if(32'h8000_0004, 32'h3C01_1234, 1'b0, 7);
    step(30);
`ifdef ARB_FAIRNESS_EN
    // Back-to-back contention: third grant goes to IF
    issue_mem(1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 3);
    issue_mem(1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 7);
    issue_mem(1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 15);
    issue_if(32'h8000_0004, 32'h3C01_1234, 1'b0, 11);
    step(60);
`endif

    // 4: independent channels complete in parallel
    issue_if(32'h8000_0000, 32'hCAFE_F00D, 1'b0, 3);
    issue_mem(1'b0, 32'h8040_0000, 32'h0, 4'hF, 32'h0BAD_C0DE, 1'b0, 3);
    step(20);

    // 5: error decode on both ports, no chip activity
    clear_mon();
    issue_mem(1'b0, 32'hBFD0_03F8, 32'h0, 4'hF, 32'h0, 1'b1, 1);
    issue_if(32'h0000_1000, 32'h0, 1'b1, 1);
    step(20);
    check("t5_base_ce_activity", 32'(base_ce_lo), 0);
    check("t5_ext_ce_activity", 32'(ext_ce_lo), 0);

    // 6: reset during the first ACCESS cycle of a write
    mem_addr = 32'h8040_0020; mem_we = 1'b1; mem_wdata = 32'h0; mem_be = 4'hF; mem_req = 1'b1;
    @(negedge clk); sample();
    check("t6_in_access_ce_n", 32'(ext_ram_ce_n), 0);
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("t6_rst_ext_n", {29'b0, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h7);
    check("t6_rst_be_n", {28'b0, ext_ram_be_n}, 32'hF);
    check("t6_rst_mem_ack", 32'(mem_ack), 0);
    check("t6_rst_mem_rdata", mem_rdata, 0);
    rst = 1'b0;
    repeat (4) begin @(negedge clk); sample(); end
    issue_mem(1'b0, 32'h8040_0020, 32'h0, 4'hF, 32'h55AA_55AA, 1'b0, 3);
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
